// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the
// multiplier sequencer state encoding.
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  localparam int ALU_CNT_W = $clog2(ALU_WIDTH);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/mul_ctrl.sv
// Shift-add multiplier sequencer: handshake FSM plus
// iteration counter, emitting load/step/done strobes.
module mul_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic busy,
  output logic load,
  output logic step,
  output logic done_state
);

  mul_state_e       state;
  mul_state_e       nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (load)
        cnt <= '0;
      else if (step)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      MUL_IDLE: if (in_valid) nxt = MUL_RUN;
      MUL_RUN:  if (last) nxt = MUL_DONE;
      MUL_DONE: if (out_ready) nxt = MUL_IDLE;
      default:  nxt = MUL_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    done_state = 1'b0;
    unique case (state)
      MUL_IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      MUL_RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      MUL_DONE: begin
        busy       = 1'b1;
        done_state = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Radix-2 shift-add unsigned multiplier; one adder pass
// per cycle, 2*WIDTH-bit product over valid/ready.
module seq_mul_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  logic             load;
  logic             step;
  logic             done_state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] sum;
  logic             carry;

  mul_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .busy      (busy),
    .load      (load),
    .step      (step),
    .done_state(done_state)
  );

  always_comb begin
    if (acc_lo[0])
      {carry, sum} = {1'b0, acc_hi} + {1'b0, mcand};
    else
      {carry, sum} = {1'b0, acc_hi};
  end

  // carry lands in acc_hi MSB through the 2W+1-bit shift
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (load) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
    end else if (step) begin
      {acc_hi, acc_lo} <= {carry, sum, acc_lo[WIDTH-1:1]};
    end
  end

  assign product   = {acc_hi, acc_lo};
  assign out_valid = done_state;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed scoreboard bench for seq_mul_unit.
// Checks products, latency, backpressure and reset.
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];

  seq_mul_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic op(input string tag,
                    input logic [31:0] oa,
                    input logic [31:0] ob,
                    input int bp,
                    input bit keep);
    int waits;
    int cyc;
    logic [63:0] held;
    logic [63:0] exp;
    a        = oa;
    b        = ob;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 100) begin
      tick();
      waits++;
    end
    if (keep) chk({tag, "_acc_gap"}, 64'(waits), 64'd0);
    tick();
    sb.push_back(64'(oa) * 64'(ob));
    if (!keep) in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
    out_ready = (bp == 0);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    if (bp > 0) begin
      held = product;
      for (int i = 0; i < bp; i++) begin
        in_valid = i[0];
        a = 32'd1;
        b = 32'd1;
        tick();
      end
      in_valid = 1'b0;
      chk({tag, "_hold"}, product, held);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_ovhold"}, 64'(out_valid), 64'd1);
      out_ready = 1'b1;
    end
    exp = sb.pop_front();
    chk({tag, "_prod"}, product, exp);
    tick();
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_ovlo"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", product, 64'd0);

    op("basic", 32'd3, 32'd5, 0, 1'b0);
    op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    op("zero_a", 32'd0, 32'h12345678, 0, 1'b0);
    op("zero_b", 32'hDEADBEEF, 32'd0, 0, 1'b0);
    op("bp", 32'h10000, 32'h10000, 10, 1'b0);
    chk("bp_idle", 64'(busy), 64'd0);

    // abort an operation mid-run
    a        = 32'd7;
    b        = 32'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 12; i++) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_product", product, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mrst_no_pulse", 64'(seen), 64'd0);
    op("after_rst", 32'd2, 32'd3, 0, 1'b0);

    // reset wins over a simultaneous request
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 32'd11;
    b        = 32'd13;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid", 64'(busy), 64'd0);
    tick();
    chk("rst_vs_valid2", 64'(busy), 64'd0);

    op("b2b0", 32'h00000011, 32'h00000101, 0, 1'b1);
    op("b2b1", 32'h80000000, 32'h00000003, 0, 1'b1);
    op("b2b2", 32'hCAFEF00D, 32'h0BADBEEF, 0, 1'b1);
    op("b2b3", 32'h7FFFFFFF, 32'hFFFFFFFE, 0, 1'b1);
    in_valid = 1'b0;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    tick();
    tick();
    chk("b2b_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
